// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS writeback slice.
//   load_type_t     : load kind encoding carried on load_type
//   REG_ZERO        : hardwired-zero register index (never written)
//   tracker_state_t : outstanding-load tracker states
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    LWL = 3'd5,
    LWR = 3'd6
  } load_type_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } tracker_state_t;

endpackage

// File: rtl/mips_cpu_load_formatter.sv
// Combinational load-data formatter.
//   load_type : load kind (load_type_t encoding)
//   offset    : byte address bits [1:0]
//   mem       : aligned little-endian memory word
//   old_rt    : current rt value, merged by LWL/LWR
//   data      : formatted register value
//   err       : undefined load_type (data is mem unchanged)
module mips_cpu_load_formatter
  import mips_cpu_pkg::*;
(
  input  logic [2:0]  load_type,
  input  logic [1:0]  offset,
  input  logic [31:0] mem,
  input  logic [31:0] old_rt,
  output logic [31:0] data,
  output logic        err
);

  logic [4:0]  sh_r;
  logic [4:0]  sh_l;
  logic [7:0]  bsel;
  logic [15:0] hsel;

  // sh_l = 8*(3-offset); for a 2-bit offset, 3-offset equals ~offset
  assign sh_r = {offset, 3'b000};
  assign sh_l = {~offset, 3'b000};
  assign bsel = mem[sh_r +: 8];
  assign hsel = offset[1] ? mem[31:16] : mem[15:0];

  always_comb begin
    data = mem;
    err  = 1'b0;
    case (load_type_t'(load_type))
      LB:      data = {{24{bsel[7]}}, bsel};
      LBU:     data = {24'h000000, bsel};
      LH:      data = {{16{hsel[15]}}, hsel};
      LHU:     data = {16'h0000, hsel};
      LW:      data = mem;
      LWL:     data = (mem << sh_l) | (old_rt & ((32'h1 << sh_l) - 32'h1));
      LWR:     data = (mem >> sh_r) | (old_rt & ~(32'hFFFF_FFFF >> sh_r));
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_cpu_writeback_unit.sv
// Register-file write-port producer.
//   alu_valid/alu_reg/alu_data/alu_ready : single-cycle ALU results
//   load_issue/load_reg/load_type/load_offset/load_old_rt/load_ready :
//     load issue side; one load outstanding at a time
//   mem_readdata_valid/mem_readdata : returned memory word
//   write_enable/write_reg/write_data : register-file write port
//   load_pending/load_pending_reg : outstanding-load status for hazard logic
//   protocol_error : sticky protocol violation flag
module mips_cpu_writeback_unit
  import mips_cpu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        load_issue,
  input  logic [4:0]  load_reg,
  input  logic [2:0]  load_type,
  input  logic [1:0]  load_offset,
  input  logic [31:0] load_old_rt,
  output logic        load_ready,
  input  logic        mem_readdata_valid,
  input  logic [31:0] mem_readdata,
  output logic        write_enable,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        load_pending,
  output logic [4:0]  load_pending_reg,
  output logic        protocol_error
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  tracker_state_t state, state_next;
  logic [4:0]     ld_reg_q;
  logic [2:0]     ld_type_q;
  logic [1:0]     ld_off_q;
  logic [31:0]    ld_old_q;
  logic           capture, load_done, err_set;
  logic [31:0]    fmt_data;
  logic           fmt_err;

  logic [4:0]     q_reg  [FIFO_DEPTH];
  logic [31:0]    q_data [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr, alu_slot;
  logic [CW-1:0]  count;
  logic [CW:0]    free;
  logic           nonempty, load_enq, alu_enq, store_load, store_alu;

  mips_cpu_load_formatter u_fmt (
    .load_type (ld_type_q),
    .offset    (ld_off_q),
    .mem       (mem_readdata),
    .old_rt    (ld_old_q),
    .data      (fmt_data),
    .err       (fmt_err)
  );

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    load_done  = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (load_issue) begin
          capture    = 1'b1;
          state_next = WAIT_MEM;
        end
        if (mem_readdata_valid) err_set = 1'b1;
      end
      WAIT_MEM: begin
        if (mem_readdata_valid) begin
          load_done  = 1'b1;
          state_next = IDLE;
          if (fmt_err) err_set = 1'b1;
        end
        if (load_issue) err_set = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ld_reg_q       <= '0;
      ld_type_q      <= '0;
      ld_off_q       <= '0;
      ld_old_q       <= '0;
      protocol_error <= 1'b0;
      load_ready     <= 1'b1;
    end else begin
      state      <= state_next;
      load_ready <= (state_next == IDLE);
      if (capture) begin
        ld_reg_q  <= load_reg;
        ld_type_q <= load_type;
        ld_off_q  <= load_offset;
        ld_old_q  <= load_old_rt;
      end
      if (err_set) protocol_error <= 1'b1;
    end
  end

  assign load_pending     = (state == WAIT_MEM);
  assign load_pending_reg = ld_reg_q;

  // The output register is the oldest write slot: with an empty queue the
  // first arrival bypasses storage, so free counts the slot vacated this cycle.
  assign nonempty   = (count != '0);
  assign free       = DEPTH_W - {1'b0, count} + (CW+1)'(nonempty);
  assign alu_ready  = free >= ((CW+1)'(1) + (CW+1)'(load_done));
  assign load_enq   = load_done && (ld_reg_q != REG_ZERO);
  assign alu_enq    = alu_valid && alu_ready && (alu_reg != REG_ZERO);
  assign store_load = load_enq && nonempty;
  assign store_alu  = alu_enq && (nonempty || load_enq);
  assign alu_slot   = wr_ptr + AW'(store_load);

  always_ff @(posedge clk) begin
    if (store_load) begin
      q_reg[wr_ptr]  <= ld_reg_q;
      q_data[wr_ptr] <= fmt_data;
    end
    if (store_alu) begin
      q_reg[alu_slot]  <= alu_reg;
      q_data[alu_slot] <= alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      write_enable <= 1'b0;
      write_reg    <= '0;
      write_data   <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(store_load) + AW'(store_alu);
      rd_ptr <= rd_ptr + AW'(nonempty);
      count  <= count + CW'(store_load) + CW'(store_alu) - CW'(nonempty);
      write_enable <= nonempty || load_enq || alu_enq;
      if (nonempty) begin
        write_reg  <= q_reg[rd_ptr];
        write_data <= q_data[rd_ptr];
      end else if (load_enq) begin
        write_reg  <= ld_reg_q;
        write_data <= fmt_data;
      end else if (alu_enq) begin
        write_reg  <= alu_reg;
        write_data <= alu_data;
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_writeback_unit.sv
module tb_mips_cpu_writeback_unit;
  import mips_cpu_pkg::*;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_reg = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        load_issue = 1'b0;
  logic [4:0]  load_reg = '0;
  logic [2:0]  load_type = '0;
  logic [1:0]  load_offset = '0;
  logic [31:0] load_old_rt = '0;
  logic        load_ready;
  logic        mem_readdata_valid = 1'b0;
  logic [31:0] mem_readdata = '0;
  logic        write_enable;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        load_pending;
  logic [4:0]  load_pending_reg;
  logic        protocol_error;

  mips_cpu_writeback_unit #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .load_issue(load_issue), .load_reg(load_reg), .load_type(load_type),
    .load_offset(load_offset), .load_old_rt(load_old_rt), .load_ready(load_ready),
    .mem_readdata_valid(mem_readdata_valid), .mem_readdata(mem_readdata),
    .write_enable(write_enable), .write_reg(write_reg), .write_data(write_data),
    .load_pending(load_pending), .load_pending_reg(load_pending_reg),
    .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending register writes in program order,
  // plus a record of the single outstanding load.
  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  bit          m_pend;
  logic [4:0]  m_reg;
  logic [2:0]  m_type;
  logic [1:0]  m_off;
  logic [31:0] m_old;
  bit          m_err;
  bit          e_we;
  logic [4:0]  e_reg;
  logic [31:0] e_data;
  bit          e_ready;
  bit          last_ar;

  int tests = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void ref_fmt(input logic [2:0] t, input logic [1:0] b,
                                  input logic [31:0] mem, input logic [31:0] old,
                                  output logic [31:0] res, output bit bad);
    logic [7:0] mb[4];
    logic [7:0] ob[4];
    logic [7:0] rb[4];
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    int s;
    int h;
    for (int k = 0; k < 4; k++) begin
      mb[k] = mem[8*k +: 8];
      ob[k] = old[8*k +: 8];
    end
    h   = b[1] ? 2 : 0;
    s   = 3 - int'(b);
    bad = 0;
    res = mem;
    case (t)
      3'd0: begin sb = mb[b]; res = sb; end
      3'd1: res = {24'h0, mb[b]};
      3'd2: begin sh = {mb[h+1], mb[h]}; res = sh; end
      3'd3: res = {16'h0, mb[h+1], mb[h]};
      3'd4: res = mem;
      3'd5: begin
        for (int k = 0; k < 4; k++) rb[k] = (k >= s) ? mb[k-s] : ob[k];
        res = {rb[3], rb[2], rb[1], rb[0]};
      end
      3'd6: begin
        for (int k = 0; k < 4; k++) rb[k] = (k <= s) ? mb[k+int'(b)] : ob[k];
        res = {rb[3], rb[2], rb[1], rb[0]};
      end
      default: bad = 1;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    m_pend  = 0;
    m_reg   = '0;
    m_err   = 0;
    e_we    = 0;
    e_reg   = '0;
    e_data  = '0;
    e_ready = 1;
  endtask

  task automatic model_update();
    logic [31:0] res;
    bit bad;
    ent_t e;
    if (load_issue && m_pend) m_err = 1;
    if (mem_readdata_valid && !m_pend) m_err = 1;
    if (m_pend && mem_readdata_valid) begin
      ref_fmt(m_type, m_off, mem_readdata, m_old, res, bad);
      if (bad) m_err = 1;
      if (m_reg != 5'd0) q.push_back('{m_reg, res});
      m_pend = 0;
    end else if (!m_pend && load_issue) begin
      m_reg  = load_reg;
      m_type = load_type;
      m_off  = load_offset;
      m_old  = load_old_rt;
      m_pend = 1;
    end
    if (alu_valid && last_ar && alu_reg != 5'd0) q.push_back('{alu_reg, alu_data});
    if (q.size() > 0) begin
      e      = q.pop_front();
      e_we   = 1;
      e_reg  = e.r;
      e_data = e.d;
    end else begin
      e_we = 0;
    end
    e_ready = !m_pend;
  endtask

  // One clock cycle with the currently driven inputs.
  task automatic step();
    int sz;
    int fr;
    int lv;
    #1;
    sz = q.size();
    fr = D - sz + ((sz > 0) ? 1 : 0);
    lv = (m_pend && mem_readdata_valid) ? 1 : 0;
    last_ar = (fr >= 1 + lv);
    if (!reset) check("alu_ready", alu_ready, last_ar);
    if (reset) model_reset(); else model_update();
    @(posedge clk);
    #1;
    check("write_enable", write_enable, e_we);
    check("write_reg", write_reg, e_reg);
    check("write_data", write_data, e_data);
    check("load_pending", load_pending, m_pend);
    if (m_pend) check("load_pending_reg", load_pending_reg, m_reg);
    check("load_ready", load_ready, e_ready);
    check("protocol_error", protocol_error, m_err);
  endtask

  task automatic set_alu(input logic v, input logic [4:0] r, input logic [31:0] d);
    alu_valid = v;
    alu_reg   = r;
    alu_data  = d;
  endtask

  task automatic do_load(input logic [4:0] r, input logic [2:0] t, input logic [1:0] off,
                         input logic [31:0] old, input logic [31:0] mem, input int lat,
                         input logic [31:0] expv, input string tag);
    load_issue = 1; load_reg = r; load_type = t; load_offset = off; load_old_rt = old;
    step();
    load_issue = 0;
    repeat (lat) begin
      step();
      check({tag, "_pend_reg"}, load_pending_reg, r);
      check({tag, "_ready_low"}, load_ready, 0);
    end
    mem_readdata_valid = 1; mem_readdata = mem;
    step();
    mem_readdata_valid = 0;
    check({tag, "_we"}, write_enable, 1);
    check({tag, "_reg"}, write_reg, r);
    check(tag, write_data, expv);
  endtask

  initial begin
    model_reset();
    last_ar = 1;
    reset = 1;
    step();
    step();
    reset = 0;
    check("reset_we", write_enable, 0);
    check("reset_data", write_data, 0);
    check("reset_ready", load_ready, 1);
    check("reset_err", protocol_error, 0);

    // ALU write appears the next cycle; register 0 is never written
    set_alu(1, 5'd3, 32'h12345678);
    step();
    set_alu(0, 5'd0, 32'h0);
    check("alu_we", write_enable, 1);
    check("alu_reg", write_reg, 3);
    check("alu_data", write_data, 32'h12345678);
    set_alu(1, 5'd0, 32'hDEADBEEF);
    step();
    set_alu(0, 5'd0, 32'h0);
    check("alu_r0_we", write_enable, 0);
    step();
    check("alu_r0_we2", write_enable, 0);
    check("hold_data", write_data, 32'h12345678);

    // Load formatting
    do_load(5'd1, LB,  2'd3, 32'h0,        32'h80AABBCC, 1, 32'hFFFFFF80, "lb3");
    do_load(5'd2, LBU, 2'd0, 32'h0,        32'h80AABBCC, 0, 32'h000000CC, "lbu0");
    do_load(5'd3, LHU, 2'd2, 32'h0,        32'h80AABBCC, 2, 32'h000080AA, "lhu2");
    do_load(5'd4, LH,  2'd2, 32'h0,        32'h80AABBCC, 0, 32'hFFFF80AA, "lh2");
    do_load(5'd5, LWL, 2'd1, 32'h11223344, 32'hAABBCCDD, 0, 32'hCCDD3344, "lwl1");
    do_load(5'd6, LWR, 2'd1, 32'h11223344, 32'hAABBCCDD, 1, 32'h11AABBCC, "lwr1");
    do_load(5'd7, LWL, 2'd3, 32'h11223344, 32'hAABBCCDD, 0, 32'hAABBCCDD, "lwl3");
    // Latency 5 with the pending status held throughout
    do_load(5'd8, LW,  2'd0, 32'h0,        32'hCAFEF00D, 5, 32'hCAFEF00D, "lat5");
    check("lat5_ready_back", load_ready, 1);
    check("lat5_err_clean", protocol_error, 0);

    // Load data and ALU result together: load first, ALU next cycle
    load_issue = 1; load_reg = 5'd9; load_type = LW; load_offset = 0;
    step();
    load_issue = 0;
    mem_readdata_valid = 1; mem_readdata = 32'h0000AAAA;
    set_alu(1, 5'd10, 32'h0000BBBB);
    step();
    mem_readdata_valid = 0;
    set_alu(0, 5'd0, 32'h0);
    check("simul_first_reg", write_reg, 9);
    step();
    check("simul_second_we", write_enable, 1);
    check("simul_second_reg", write_reg, 10);
    step();

    // Fill the queue to two entries, then load data blocks the ALU
    set_alu(1, 5'd11, 32'h111);
    load_issue = 1; load_reg = 5'd20;
    step();
    load_issue = 0; mem_readdata_valid = 1; mem_readdata = 32'h20;
    set_alu(1, 5'd12, 32'h112);
    step();
    mem_readdata_valid = 0; load_issue = 1; load_reg = 5'd21;
    set_alu(1, 5'd13, 32'h113);
    step();
    load_issue = 0; mem_readdata_valid = 1; mem_readdata = 32'h21;
    set_alu(1, 5'd14, 32'h114);
    step();
    mem_readdata_valid = 0; load_issue = 1; load_reg = 5'd22;
    set_alu(1, 5'd15, 32'h115);
    step();
    load_issue = 0; mem_readdata_valid = 1; mem_readdata = 32'h22;
    set_alu(1, 5'd16, 32'h116);
    #1;
    check("full_alu_ready_low", alu_ready, 0);
    step();
    mem_readdata_valid = 0;
    #1;
    check("full_alu_ready_back", alu_ready, 1);
    step();
    set_alu(0, 5'd0, 32'h0);
    repeat (4) step();

    // Second issue while waiting is ignored and flagged
    load_issue = 1; load_reg = 5'd4; load_type = LW;
    step();
    load_reg = 5'd5;
    step();
    load_issue = 0;
    check("dup_issue_err", protocol_error, 1);
    check("dup_issue_pend_reg", load_pending_reg, 4);
    mem_readdata_valid = 1; mem_readdata = 32'h44;
    step();
    mem_readdata_valid = 0;
    check("dup_issue_write_reg", write_reg, 4);
    reset = 1;
    step();
    reset = 0;
    check("reset_clears_err", protocol_error, 0);

    // Reset cancels an outstanding load; its late data is dropped
    load_issue = 1; load_reg = 5'd6;
    step();
    load_issue = 0; reset = 1;
    step();
    reset = 0; mem_readdata_valid = 1; mem_readdata = 32'h66;
    step();
    mem_readdata_valid = 0;
    check("late_data_no_write", write_enable, 0);
    check("late_data_err", protocol_error, 1);
    step();
    check("late_data_no_write2", write_enable, 0);
    reset = 1;
    step();
    reset = 0;
    check("reset_again_err", protocol_error, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(99) == 0);
      if (!(alu_valid && !last_ar)) begin
        alu_valid = $urandom_range(1);
        alu_reg   = 5'($urandom_range(31));
        alu_data  = $urandom;
      end
      load_issue = m_pend ? ($urandom_range(39) == 0) : ($urandom_range(2) == 0);
      load_reg    = 5'($urandom_range(31));
      load_type   = ($urandom_range(39) == 0) ? 3'd7 : 3'($urandom_range(6));
      load_offset = 2'($urandom_range(3));
      load_old_rt = $urandom;
      mem_readdata_valid = m_pend ? ($urandom_range(2) == 0) : ($urandom_range(59) == 0);
      mem_readdata = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
